// File: rtl/leglite_multicycle_control_if.sv
// Control bundle between the LEGLite multi-cycle controller (master) and the datapath (slave).
interface leglite_multicycle_control_if #(
    parameter int OPCODE_W  = 4,
    parameter int ALU_SEL_W = 3
) ();
    logic                 run;
    logic [OPCODE_W-1:0]  opcode;
    logic                 zero;
    logic                 mem_ready;
    logic                 reg2loc;
    logic                 uncondbranch;
    logic                 branch;
    logic                 memread;
    logic                 memtoreg;
    logic                 memwrite;
    logic                 alusrc;
    logic                 regwrite;
    logic [ALU_SEL_W-1:0] alu_select;
    logic                 ir_write;
    logic                 pc_write;
    logic                 pc_src;
    logic                 instr_done;
    logic                 mem_timeout;
    logic                 illegal;
    logic [2:0]           state;

    modport master (
        input  run, opcode, zero, mem_ready,
        output reg2loc, uncondbranch, branch, memread, memtoreg, memwrite, alusrc, regwrite,
               alu_select, ir_write, pc_write, pc_src, instr_done, mem_timeout, illegal, state
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  reg2loc, uncondbranch, branch, memread, memtoreg, memwrite, alusrc, regwrite,
               alu_select, ir_write, pc_write, pc_src, instr_done, mem_timeout, illegal, state
    );
endinterface

// File: rtl/leglite_multicycle_control.sv
// LEGLite multi-cycle controller sequencing FETCH/DECODE/EXEC/MEM/WB with a memory ready/timeout handshake.
// Optional macro LEGLITE_ILLEGAL_TRAP_EN: undefined opcodes trap into HALT instead of executing as a NOP.
module leglite_multicycle_control #(
    parameter int OPCODE_W    = 4,
    parameter int ALU_SEL_W   = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    leglite_multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        st_idle   = 3'd0,
        st_fetch  = 3'd1,
        st_decode = 3'd2,
        st_exec   = 3'd3,
        st_mem    = 3'd4,
        st_wb     = 3'd5,
        st_halt   = 3'd6
    } state_t;

    localparam logic [OPCODE_W-1:0]  op_add  = OPCODE_W'(4'd0);
    localparam logic [OPCODE_W-1:0]  op_sub  = OPCODE_W'(4'd1);
    localparam logic [OPCODE_W-1:0]  op_and  = OPCODE_W'(4'd2);
    localparam logic [OPCODE_W-1:0]  op_or   = OPCODE_W'(4'd3);
    localparam logic [OPCODE_W-1:0]  op_addi = OPCODE_W'(4'd4);
    localparam logic [OPCODE_W-1:0]  op_ldur = OPCODE_W'(4'd5);
    localparam logic [OPCODE_W-1:0]  op_stur = OPCODE_W'(4'd6);
    localparam logic [OPCODE_W-1:0]  op_cbz  = OPCODE_W'(4'd7);
    localparam logic [OPCODE_W-1:0]  op_b    = OPCODE_W'(4'd8);

    localparam logic [ALU_SEL_W-1:0] alu_add    = ALU_SEL_W'(3'd0);
    localparam logic [ALU_SEL_W-1:0] alu_sub    = ALU_SEL_W'(3'd1);
    localparam logic [ALU_SEL_W-1:0] alu_and    = ALU_SEL_W'(3'd2);
    localparam logic [ALU_SEL_W-1:0] alu_or     = ALU_SEL_W'(3'd3);
    localparam logic [ALU_SEL_W-1:0] alu_pass_b = ALU_SEL_W'(3'd4);

    // Last wait-count value before the MEM access is abandoned.
    localparam logic [7:0] wait_last = 8'(MEM_TIMEOUT - 1);

    function automatic logic op_defined(input logic [OPCODE_W-1:0] op);
        return (op <= op_b);
    endfunction

    function automatic logic op_is_mem(input logic [OPCODE_W-1:0] op);
        return (op == op_ldur) || (op == op_stur);
    endfunction

    function automatic logic op_is_branch(input logic [OPCODE_W-1:0] op);
        return (op == op_cbz) || (op == op_b);
    endfunction

    state_t               state_r;
    state_t               after_done_s;
    logic [OPCODE_W-1:0]  op_q_r;
    logic [7:0]           wait_cnt_r;
    logic                 mem_timeout_r;
`ifdef LEGLITE_ILLEGAL_TRAP_EN
    logic                 illegal_r;
`endif

    logic                 reg2loc_s;
    logic                 uncondbranch_s;
    logic                 branch_s;
    logic                 memread_s;
    logic                 memtoreg_s;
    logic                 memwrite_s;
    logic                 alusrc_s;
    logic                 regwrite_s;
    logic [ALU_SEL_W-1:0] alu_select_s;
    logic                 ir_write_s;
    logic                 pc_write_s;
    logic                 pc_src_s;
    logic                 instr_done_s;

    assign after_done_s = bus.run ? st_fetch : st_idle;

    // State sequencing, opcode latch, MEM wait counter and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= st_idle;
            op_q_r        <= '0;
            wait_cnt_r    <= 8'd0;
            mem_timeout_r <= 1'b0;
`ifdef LEGLITE_ILLEGAL_TRAP_EN
            illegal_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                st_idle:   state_r <= after_done_s;
                st_fetch:  state_r <= st_decode;
                st_decode: begin
                    op_q_r <= bus.opcode;
                    if (op_defined(bus.opcode)) begin
                        state_r <= st_exec;
                    end else begin
`ifdef LEGLITE_ILLEGAL_TRAP_EN
                        illegal_r <= 1'b1;
                        state_r   <= st_halt;
`else
                        state_r   <= st_wb;
`endif
                    end
                end
                st_exec: begin
                    if (op_is_branch(op_q_r)) begin
                        state_r <= after_done_s;
                    end else if (op_is_mem(op_q_r)) begin
                        wait_cnt_r <= 8'd0;
                        state_r    <= st_mem;
                    end else begin
                        state_r <= st_wb;
                    end
                end
                st_mem: begin
                    // A ready on the final allowed cycle still completes the access.
                    if (bus.mem_ready) begin
                        wait_cnt_r <= 8'd0;
                        state_r    <= (op_q_r == op_ldur) ? st_wb : after_done_s;
                    end else if (wait_cnt_r == wait_last) begin
                        wait_cnt_r    <= 8'd0;
                        mem_timeout_r <= 1'b1;
                        state_r       <= st_idle;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                st_wb: state_r <= after_done_s;
`ifdef LEGLITE_ILLEGAL_TRAP_EN
                st_halt: state_r <= st_halt;
`endif
                default: state_r <= st_idle;
            endcase
        end
    end

    // Control decode from the current state and (latched) opcode.
    always_comb begin
        reg2loc_s      = 1'b0;
        uncondbranch_s = 1'b0;
        branch_s       = 1'b0;
        memread_s      = 1'b0;
        memtoreg_s     = 1'b0;
        memwrite_s     = 1'b0;
        alusrc_s       = 1'b0;
        regwrite_s     = 1'b0;
        alu_select_s   = alu_add;
        ir_write_s     = 1'b0;
        pc_write_s     = 1'b0;
        pc_src_s       = 1'b0;
        instr_done_s   = 1'b0;
        case (state_r)
            st_fetch:  ir_write_s = 1'b1;
            st_decode: reg2loc_s  = (bus.opcode == op_stur) || (bus.opcode == op_cbz);
            st_exec: begin
                case (op_q_r)
                    op_sub:  alu_select_s = alu_sub;
                    op_and:  alu_select_s = alu_and;
                    op_or:   alu_select_s = alu_or;
                    op_cbz:  alu_select_s = alu_pass_b;
                    default: alu_select_s = alu_add;
                endcase
                alusrc_s = (op_q_r == op_addi) || op_is_mem(op_q_r);
                if (op_q_r == op_cbz) begin
                    branch_s     = 1'b1;
                    pc_write_s   = 1'b1;
                    pc_src_s     = bus.zero;
                    instr_done_s = 1'b1;
                end else if (op_q_r == op_b) begin
                    uncondbranch_s = 1'b1;
                    pc_write_s     = 1'b1;
                    pc_src_s       = 1'b1;
                    instr_done_s   = 1'b1;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            st_mem: begin
                memread_s  = (op_q_r == op_ldur);
                memwrite_s = (op_q_r == op_stur);
                if (bus.mem_ready && (op_q_r == op_stur)) begin
                    pc_write_s   = 1'b1;
                    instr_done_s = 1'b1;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            st_wb: begin
                // Undefined opcodes reach WB only as a NOP: no register write.
                regwrite_s   = op_defined(op_q_r);
                memtoreg_s   = (op_q_r == op_ldur);
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
            end
            default: ir_write_s = 1'b0;
        endcase
    end

    assign bus.reg2loc      = reg2loc_s;
    assign bus.uncondbranch = uncondbranch_s;
    assign bus.branch       = branch_s;
    assign bus.memread      = memread_s;
    assign bus.memtoreg     = memtoreg_s;
    assign bus.memwrite     = memwrite_s;
    assign bus.alusrc       = alusrc_s;
    assign bus.regwrite     = regwrite_s;
    assign bus.alu_select   = alu_select_s;
    assign bus.ir_write     = ir_write_s;
    assign bus.pc_write     = pc_write_s;
    assign bus.pc_src       = pc_src_s;
    assign bus.instr_done   = instr_done_s;
    assign bus.mem_timeout  = mem_timeout_r;
    assign bus.state        = state_r;
`ifdef LEGLITE_ILLEGAL_TRAP_EN
    assign bus.illegal      = illegal_r;
`else
    assign bus.illegal      = 1'b0;
`endif
endmodule

// File: tb/tb_leglite_multicycle_control.sv
// Directed self-checking bench for leglite_multicycle_control (MEM_TIMEOUT=16).
module tb_leglite_multicycle_control;
    logic clock;
    logic reset;
    int   errors;
    int   checks;

    leglite_multicycle_control_if #(.OPCODE_W(4), .ALU_SEL_W(3)) bus ();

    leglite_multicycle_control #(.OPCODE_W(4), .ALU_SEL_W(3), .MEM_TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // {state, reg2loc, uncondbranch, branch, memread, memtoreg, memwrite, alusrc, regwrite,
    //  alu_select[2:0], ir_write, pc_write, pc_src, instr_done}
    function automatic logic [17:0] obs();
        return {bus.state, bus.reg2loc, bus.uncondbranch, bus.branch, bus.memread, bus.memtoreg,
                bus.memwrite, bus.alusrc, bus.regwrite, bus.alu_select, bus.ir_write,
                bus.pc_write, bus.pc_src, bus.instr_done};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.run = 1'b0;
        bus.opcode = 4'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (obs() !== 18'h00000) begin
            errors++; $display("FAIL reset_ctl: got %h want %h", obs(), 18'h00000);
        end
        checks++;
        if ({bus.mem_timeout, bus.illegal} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b want %b", {bus.mem_timeout, bus.illegal}, 2'b00);
        end
        bus.run = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== {3'd1, 15'h0008}) begin
            errors++; $display("FAIL reset_sync_hold: got %h want %h", obs(), {3'd1, 15'h0008});
        end
        tick();
        #1;
        checks++;
        if (obs() !== 18'h00000) begin
            errors++; $display("FAIL reset_sync_apply: got %h want %h", obs(), 18'h00000);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [17:0] exp_v [6];
        exp_v = '{{3'd0, 15'h0000}, {3'd1, 15'h0008}, {3'd2, 15'h0000},
                  {3'd3, 15'h0000}, {3'd5, 15'h0085}, {3'd1, 15'h0008}};
        do_reset();
        bus.run = 1'b1;
        bus.opcode = 4'd0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++; $display("FAIL add cyc%0d: got %h want %h", i, obs(), exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_ldur();
        logic [17:0] exp_v [10];
        exp_v = '{{3'd0, 15'h0000}, {3'd1, 15'h0008}, {3'd2, 15'h0000}, {3'd3, 15'h0100},
                  {3'd4, 15'h0800}, {3'd4, 15'h0800}, {3'd4, 15'h0800}, {3'd4, 15'h0800},
                  {3'd5, 15'h0485}, {3'd1, 15'h0008}};
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.opcode = (i <= 2) ? 4'd5 : 4'd0;
            bus.mem_ready = (i == 7);
            #1;
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++; $display("FAIL ldur cyc%0d: got %h want %h", i, obs(), exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_cbz();
        logic [17:0] exp_v [8];
        exp_v = '{{3'd0, 15'h0000}, {3'd1, 15'h0008}, {3'd2, 15'h4000}, {3'd3, 15'h1047},
                  {3'd1, 15'h0008}, {3'd2, 15'h4000}, {3'd3, 15'h1045}, {3'd1, 15'h0008}};
        do_reset();
        bus.run = 1'b1;
        bus.opcode = 4'd7;
        for (int i = 0; i < 8; i++) begin
            bus.zero = (i <= 3);
            #1;
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++; $display("FAIL cbz cyc%0d: got %h want %h", i, obs(), exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_stur_ready();
        logic [17:0] exp_v [7];
        exp_v = '{{3'd0, 15'h0000}, {3'd1, 15'h0008}, {3'd2, 15'h4000}, {3'd3, 15'h0100},
                  {3'd4, 15'h0200}, {3'd4, 15'h0205}, {3'd1, 15'h0008}};
        do_reset();
        bus.run = 1'b1;
        bus.opcode = 4'd6;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = (i == 5);
            #1;
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++; $display("FAIL stur_ready cyc%0d: got %h want %h", i, obs(), exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_stur_timeout();
        logic [17:0] exp;
        do_reset();
        bus.run = 1'b1;
        bus.opcode = 4'd6;
        for (int i = 0; i < 22; i++) begin
            if (i == 0)       exp = {3'd0, 15'h0000};
            else if (i == 1)  exp = {3'd1, 15'h0008};
            else if (i == 2)  exp = {3'd2, 15'h4000};
            else if (i == 3)  exp = {3'd3, 15'h0100};
            else if (i <= 19) exp = {3'd4, 15'h0200};
            else if (i == 20) exp = {3'd0, 15'h0000};
            else              exp = {3'd1, 15'h0008};
            #1;
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL stur_timeout cyc%0d: got %h want %h", i, obs(), exp);
            end
            checks++;
            if (bus.mem_timeout !== (i >= 20)) begin
                errors++; $display("FAIL stur_timeout_flag cyc%0d: got %b want %b", i, bus.mem_timeout, (i >= 20));
            end
            tick();
        end
    endtask

    task automatic test_mem_boundary();
        logic [17:0] exp;
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 41; i++) begin
            bus.opcode = (i < 20) ? 4'd5 : 4'd6;
            bus.mem_ready = (i == 19) || (i == 39);
            if (i == 0)                 exp = {3'd0, 15'h0000};
            else if (i == 1)            exp = {3'd1, 15'h0008};
            else if (i == 2)            exp = {3'd2, 15'h0000};
            else if (i == 3)            exp = {3'd3, 15'h0100};
            else if (i <= 19)           exp = {3'd4, 15'h0800};
            else if (i == 20)           exp = {3'd5, 15'h0485};
            else if (i == 21)           exp = {3'd1, 15'h0008};
            else if (i == 22)           exp = {3'd2, 15'h4000};
            else if (i == 23)           exp = {3'd3, 15'h0100};
            else if (i <= 38)           exp = {3'd4, 15'h0200};
            else if (i == 39)           exp = {3'd4, 15'h0205};
            else                        exp = {3'd1, 15'h0008};
            #1;
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL mem_boundary cyc%0d: got %h want %h", i, obs(), exp);
            end
            tick();
        end
        #1;
        checks++;
        if (bus.mem_timeout !== 1'b0) begin
            errors++; $display("FAIL mem_boundary_flag: got %b want %b", bus.mem_timeout, 1'b0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4];
        logic [14:0] ex_v [4];
        logic [17:0] exp;
        ops  = '{4'd1, 4'd2, 4'd3, 4'd4};
        ex_v = '{15'h0010, 15'h0020, 15'h0030, 15'h0100};
        do_reset();
        bus.run = 1'b1;
        #1;
        checks++;
        if (obs() !== 18'h00000) begin
            errors++; $display("FAIL b2b idle: got %h want %h", obs(), 18'h00000);
        end
        tick();
        for (int j = 0; j < 4; j++) begin
            bus.opcode = ops[j];
            for (int k = 0; k < 4; k++) begin
                if (k == 0)      exp = {3'd1, 15'h0008};
                else if (k == 1) exp = {3'd2, 15'h0000};
                else if (k == 2) exp = {3'd3, ex_v[j]};
                else             exp = {3'd5, 15'h0085};
                if (j == 3 && k == 3) bus.run = 1'b0;
                #1;
                checks++;
                if (obs() !== exp) begin
                    errors++; $display("FAIL b2b op%0d cyc%0d: got %h want %h", ops[j], k, obs(), exp);
                end
                tick();
            end
        end
        #1;
        checks++;
        if (obs() !== 18'h00000) begin
            errors++; $display("FAIL b2b final_idle: got %h want %h", obs(), 18'h00000);
        end
        tick();
    endtask

    task automatic test_run_low();
        logic [17:0] exp_v [11];
        exp_v = '{{3'd0, 15'h0000}, {3'd1, 15'h0008}, {3'd2, 15'h0000}, {3'd3, 15'h2007},
                  {3'd0, 15'h0000}, {3'd0, 15'h0000}, {3'd1, 15'h0008}, {3'd2, 15'h0000},
                  {3'd3, 15'h0000}, {3'd5, 15'h0085}, {3'd0, 15'h0000}};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.run = (i == 0) || (i == 5);
            bus.opcode = (i < 5) ? 4'd8 : 4'd0;
            #1;
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++; $display("FAIL run_low cyc%0d: got %h want %h", i, obs(), exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        for (int i = 0; i < 28; i++) begin
            bus.run = (i < 26);
            bus.opcode = (i < 20) ? 4'd6 : 4'd5;
            reset = (i == 25);
            #1;
            if (i == 20 || i == 25) begin
                checks++;
                if (bus.mem_timeout !== 1'b1) begin
                    errors++; $display("FAIL rst_mem flag_set cyc%0d: got %b want %b", i, bus.mem_timeout, 1'b1);
                end
            end
            if (i == 24 || i == 25) begin
                checks++;
                if (obs() !== {3'd4, 15'h0800}) begin
                    errors++; $display("FAIL rst_mem in_mem cyc%0d: got %h want %h", i, obs(), {3'd4, 15'h0800});
                end
            end
            if (i == 26 || i == 27) begin
                checks++;
                if (obs() !== 18'h00000) begin
                    errors++; $display("FAIL rst_mem idle cyc%0d: got %h want %h", i, obs(), 18'h00000);
                end
                checks++;
                if (bus.mem_timeout !== 1'b0) begin
                    errors++; $display("FAIL rst_mem flag_clr cyc%0d: got %b want %b", i, bus.mem_timeout, 1'b0);
                end
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [17:0] exp;
        logic        exp_ill;
        do_reset();
`ifdef LEGLITE_ILLEGAL_TRAP_EN
        bus.opcode = 4'd12;
        for (int i = 0; i < 9; i++) begin
            bus.run = (i < 6);
            reset = (i == 6);
            if (i == 0)      exp = {3'd0, 15'h0000};
            else if (i == 1) exp = {3'd1, 15'h0008};
            else if (i == 2) exp = {3'd2, 15'h0000};
            else if (i <= 6) exp = {3'd6, 15'h0000};
            else             exp = {3'd0, 15'h0000};
            exp_ill = (i >= 3) && (i <= 6);
            #1;
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL illegal_trap cyc%0d: got %h want %h", i, obs(), exp);
            end
            checks++;
            if (bus.illegal !== exp_ill) begin
                errors++; $display("FAIL illegal_flag cyc%0d: got %b want %b", i, bus.illegal, exp_ill);
            end
            tick();
        end
        reset = 1'b0;
`else
        bus.run = 1'b1;
        exp_ill = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.opcode = (i < 4) ? 4'd12 : 4'd9;
            if (i == 0)                exp = {3'd0, 15'h0000};
            else if (i == 1 || i == 4) exp = {3'd1, 15'h0008};
            else if (i == 2 || i == 5) exp = {3'd2, 15'h0000};
            else if (i == 3 || i == 6) exp = {3'd5, 15'h0005};
            else                       exp = {3'd1, 15'h0008};
            #1;
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL illegal_nop cyc%0d: got %h want %h", i, obs(), exp);
            end
            checks++;
            if (bus.illegal !== exp_ill) begin
                errors++; $display("FAIL illegal_flag cyc%0d: got %b want %b", i, bus.illegal, exp_ill);
            end
            tick();
        end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.run = 1'b0;
        bus.opcode = 4'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_ldur();
        test_cbz();
        test_stur_ready();
        test_stur_timeout();
        test_mem_boundary();
        test_back_to_back();
        test_run_low();
        test_reset_mid_mem();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
